// File: rtl/sim_intf_pkg.sv
// Shared types for the co-simulation PC-check path: trace payload, FSM states
// and the default sentinel/start PCs.
package sim_intf_pkg;

  typedef logic [63:0] xlen_t;
  typedef logic [31:0] insn_t;

  typedef struct packed {
    xlen_t pc;
    insn_t insn;
  } trace_entry_t;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    ISSUE,
    WAIT,
    HALT
  } state_t;

  localparam xlen_t DEFAULT_IDLE_PC  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam xlen_t DEFAULT_START_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/commit_trace_feeder_if.sv
// Retire port plus checker pins; master is the feeder, slave is the core/checker side.
interface commit_trace_feeder_if;
  import sim_intf_pkg::*;

  logic  ret_valid;
  xlen_t ret_pc;
  insn_t ret_insn;
  logic  ret_ready;

  xlen_t chk_pc_o;
  xlen_t chk_pc_i;
  insn_t chk_insn_i;
  logic  chk_miss_i;

  modport master (
    input  ret_valid, ret_pc, ret_insn, chk_pc_i, chk_insn_i, chk_miss_i,
    output ret_ready, chk_pc_o
  );

  modport slave (
    output ret_valid, ret_pc, ret_insn, chk_pc_i, chk_insn_i, chk_miss_i,
    input  ret_ready, chk_pc_o
  );

endinterface

// File: rtl/trace_fifo.sv
// Small first-word-fall-through FIFO of retirement entries; the head and the
// PC behind it are read combinationally so the FSM can reissue without a bubble.
module trace_fifo
  import sim_intf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  trace_entry_t           wr_data,
  output trace_entry_t           head,
  output xlen_t                  head_next_pc,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rd_ptr_inc   = rd_ptr_reg + 1'b1;
  assign head         = mem[rd_ptr_reg];
  assign head_next_pc = mem[rd_ptr_inc].pc;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_feeder.sv
// Commit trace feeder: buffers core retirements and presents them one at a time
// to the co-simulation PC checker, logging PC misses and instruction mismatches.
module commit_trace_feeder
  import sim_intf_pkg::*;
#(
  parameter int    DEPTH       = 16,
  parameter xlen_t START_PC    = DEFAULT_START_PC,
  parameter xlen_t IDLE_PC     = DEFAULT_IDLE_PC,
  parameter bit    HALT_ON_ERR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  commit_trace_feeder_if.master bus,
  output logic                  synced,
  output logic [31:0]           checked_cnt,
  output logic                  pc_err,
  output logic                  insn_err,
  output xlen_t                 err_pc,
  output xlen_t                 err_exp_pc,
  output logic                  halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  trace_entry_t  ret_entry;
  trace_entry_t  fifo_head;
  xlen_t         fifo_head_next_pc;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          more_left;
  logic          first_err;

  state_t        state_reg,      state_next;
  xlen_t         chk_pc_reg,     chk_pc_next;
  logic          synced_reg,     synced_next;
  logic [31:0]   cnt_reg,        cnt_next;
  logic          pc_err_reg,     pc_err_next;
  logic          insn_err_reg,   insn_err_next;
  xlen_t         err_pc_reg,     err_pc_next;
  xlen_t         err_exp_reg,    err_exp_next;
  insn_t         exp_insn_reg,   exp_insn_next;
  logic          exp_valid_reg,  exp_valid_next;

  assign ret_entry     = '{pc: bus.ret_pc, insn: bus.ret_insn};
  assign push          = bus.ret_valid && !fifo_full;
  assign bus.ret_ready = !fifo_full;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .pop          (pop),
    .wr_data      (ret_entry),
    .head         (fifo_head),
    .head_next_pc (fifo_head_next_pc),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  // Only called in WAIT, where the FIFO is known to hold the head under check.
  assign more_left = (fifo_count != CW'(1));
  assign first_err = !(pc_err_reg || insn_err_reg);

  always_comb begin
    state_next     = state_reg;
    chk_pc_next    = IDLE_PC;
    synced_next    = synced_reg;
    cnt_next       = cnt_reg;
    pc_err_next    = pc_err_reg;
    insn_err_next  = insn_err_reg;
    err_pc_next    = err_pc_reg;
    err_exp_next   = err_exp_reg;
    exp_insn_next  = exp_insn_reg;
    exp_valid_next = exp_valid_reg;
    pop            = 1'b0;

    case (state_reg)
      SYNC: begin
        if (!fifo_empty) begin
          if (fifo_head.pc == START_PC) begin
            synced_next = 1'b1;
            state_next  = ISSUE;
            chk_pc_next = fifo_head.pc;
          end else begin
            pop = 1'b1;
          end
        end
      end
      IDLE: begin
        if (!fifo_empty) begin
          state_next  = ISSUE;
          chk_pc_next = fifo_head.pc;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (!bus.chk_miss_i) begin
          pop      = 1'b1;
          cnt_next = cnt_reg + 32'd1;
          if (exp_valid_reg && (fifo_head.insn != exp_insn_reg)) begin
            insn_err_next = 1'b1;
            if (first_err) begin
              err_pc_next  = fifo_head.pc;
              err_exp_next = fifo_head.pc;
            end
          end
          exp_insn_next  = bus.chk_insn_i;
          exp_valid_next = 1'b1;
          if (more_left) begin
            state_next  = ISSUE;
            chk_pc_next = fifo_head_next_pc;
          end else begin
            state_next = IDLE;
          end
        end else begin
          // A miss skips the instruction check; the expected word belongs to another PC.
          pc_err_next = 1'b1;
          if (first_err) begin
            err_pc_next  = fifo_head.pc;
            err_exp_next = bus.chk_pc_i;
          end
          if (HALT_ON_ERR) begin
            state_next = HALT;
          end else begin
            pop            = 1'b1;
            exp_valid_next = 1'b0;
            if (more_left) begin
              state_next  = ISSUE;
              chk_pc_next = fifo_head_next_pc;
            end else begin
              state_next = IDLE;
            end
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SYNC;
      chk_pc_reg    <= IDLE_PC;
      synced_reg    <= 1'b0;
      cnt_reg       <= '0;
      pc_err_reg    <= 1'b0;
      insn_err_reg  <= 1'b0;
      err_pc_reg    <= '0;
      err_exp_reg   <= '0;
      exp_insn_reg  <= '0;
      exp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      chk_pc_reg    <= chk_pc_next;
      synced_reg    <= synced_next;
      cnt_reg       <= cnt_next;
      pc_err_reg    <= pc_err_next;
      insn_err_reg  <= insn_err_next;
      err_pc_reg    <= err_pc_next;
      err_exp_reg   <= err_exp_next;
      exp_insn_reg  <= exp_insn_next;
      exp_valid_reg <= exp_valid_next;
    end
  end

  assign bus.chk_pc_o = chk_pc_reg;
  assign synced       = synced_reg;
  assign checked_cnt  = cnt_reg;
  assign pc_err       = pc_err_reg;
  assign insn_err     = insn_err_reg;
  assign err_pc       = err_pc_reg;
  assign err_exp_pc   = err_exp_reg;
  assign halted       = (state_reg == HALT);

endmodule

// File: tb/tb_commit_trace_feeder.sv
// Bench for commit_trace_feeder: a golden-trace checker model answers the check
// pins, and a transaction-level model of accepted retirements predicts the status.
`timescale 1ns/1ps
module tb_commit_trace_feeder;
  import sim_intf_pkg::*;

  localparam int    DEPTH    = 16;
  localparam xlen_t START_PC = 64'h0000_0000_8000_0000;
  localparam xlen_t IDLE_PC  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int    GMAX     = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  commit_trace_feeder_if bus ();
  logic        synced, pc_err, insn_err, halted;
  logic [31:0] checked_cnt;
  xlen_t       err_pc, err_exp_pc;

  commit_trace_feeder #(
    .DEPTH(DEPTH), .START_PC(START_PC), .IDLE_PC(IDLE_PC), .HALT_ON_ERR(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .synced(synced), .checked_cnt(checked_cnt),
    .pc_err(pc_err), .insn_err(insn_err), .err_pc(err_pc), .err_exp_pc(err_exp_pc),
    .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  // Golden program the checker steps through; it compares chk_pc_o on every clock.
  xlen_t gold_pc   [GMAX];
  insn_t gold_insn [GMAX];
  int    chk_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_idx        <= 0;
      bus.chk_miss_i <= 1'b0;
    end else if (bus.chk_pc_o != IDLE_PC) begin
      if (bus.chk_pc_o == gold_pc[chk_idx]) begin
        chk_idx        <= (chk_idx + 1) % GMAX;
        bus.chk_miss_i <= 1'b0;
      end else begin
        bus.chk_miss_i <= 1'b1;
      end
    end
  end
  assign bus.chk_pc_i   = gold_pc[chk_idx];
  assign bus.chk_insn_i = gold_insn[chk_idx];

  trace_entry_t acc_q[$];
  logic         e_synced, e_pc_err, e_insn_err, e_halted;
  int unsigned  e_cnt;
  xlen_t        e_err_pc, e_err_exp;

  // Replays the accepted retirements against the golden program.
  task automatic ref_eval();
    int    k     = 0;
    logic  ev    = 1'b0;
    insn_t einsn = '0;
    e_synced = 0; e_pc_err = 0; e_insn_err = 0; e_halted = 0;
    e_cnt = 0; e_err_pc = '0; e_err_exp = '0;
    foreach (acc_q[i]) begin
      if (e_halted) break;
      if (!e_synced) begin
        if (acc_q[i].pc != START_PC) continue;
        e_synced = 1'b1;
      end
      if (acc_q[i].pc != gold_pc[k]) begin
        if (!e_insn_err) begin e_err_pc = acc_q[i].pc; e_err_exp = gold_pc[k]; end
        e_pc_err = 1'b1;
        e_halted = 1'b1;
      end else begin
        if (ev && acc_q[i].insn != einsn) begin
          if (!e_insn_err) begin e_err_pc = acc_q[i].pc; e_err_exp = acc_q[i].pc; end
          e_insn_err = 1'b1;
        end
        e_cnt++;
        k++;
        einsn = gold_insn[k];
        ev    = 1'b1;
      end
    end
  endtask

  task automatic set_gold_seq(input xlen_t base, input int stride);
    for (int i = 0; i < GMAX; i++) begin
      gold_pc[i]   = base + xlen_t'(stride * i);
      gold_insn[i] = $urandom;
    end
  endtask

  // Called at a negedge; ret_ready is stable until the next posedge.
  task automatic drive_cycle(input logic v, input xlen_t p, input insn_t w, output logic acc);
    bus.ret_valid = v;
    bus.ret_pc    = p;
    bus.ret_insn  = w;
    acc = v && bus.ret_ready;
    if (acc) acc_q.push_back('{pc: p, insn: w});
    @(negedge clk);
  endtask

  task automatic push_wait(input xlen_t p, input insn_t w);
    logic acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) drive_cycle(1'b1, p, w, acc);
    bus.ret_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout pc %0h not accepted, ret_ready %0b need 1", p, bus.ret_ready);
    end
  endtask

  task automatic idle(input int n);
    bus.ret_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.ret_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.chk_pc_o !== IDLE_PC) begin errors++; $display("FAIL rst_chk_pc got %0h exp %0h", bus.chk_pc_o, IDLE_PC); end
    checks++; if (bus.ret_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", bus.ret_ready); end
    checks++; if ({synced, pc_err, insn_err, halted} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {synced, pc_err, insn_err, halted}); end
    checks++; if (checked_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", checked_cnt); end
    checks++; if ({err_pc, err_exp_pc} !== 128'd0) begin errors++; $display("FAIL rst_err_pcs got %0h/%0h exp 0/0", err_pc, err_exp_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.chk_pc_o !== IDLE_PC) begin errors++; $display("FAIL rel_chk_pc got %0h exp %0h", bus.chk_pc_o, IDLE_PC); end
  endtask

  task automatic test_sync();
    int hits = 0, other = 0;
    do_reset();
    set_gold_seq(START_PC, 4);
    push_wait(64'h1000, $urandom);
    push_wait(64'h1004, $urandom);
    push_wait(START_PC, gold_insn[0]);
    for (int c = 0; c < 12; c++) begin
      if (bus.chk_pc_o == START_PC) hits++;
      else if (bus.chk_pc_o != IDLE_PC) other++;
      @(negedge clk);
    end
    checks++; if (hits != 1 || other != 0) begin errors++; $display("FAIL sync_issue got start_cycles %0d other %0d exp 1/0", hits, other); end
    checks++; if (synced !== 1'b1) begin errors++; $display("FAIL sync_synced got %0b exp 1", synced); end
    checks++; if (checked_cnt !== 32'd1) begin errors++; $display("FAIL sync_cnt got %0d exp 1", checked_cnt); end
    checks++; if (pc_err !== 1'b0) begin errors++; $display("FAIL sync_pc_err got %0b exp 0", pc_err); end
  endtask

  task automatic test_back_to_back();
    int issues = 0, run = 0, max_run = 0;
    logic acc;
    do_reset();
    set_gold_seq(START_PC, 4);
    push_wait(START_PC, gold_insn[0]);
    idle(6);
    for (int c = 0; c < 22; c++) begin
      if (c < 8) drive_cycle(1'b1, gold_pc[c+1], gold_insn[c+1], acc);
      else drive_cycle(1'b0, '0, '0, acc);
      if (c == 2) begin checks++; if (checked_cnt !== 32'd1) begin errors++; $display("FAIL b2b_latency_early got %0d exp 1", checked_cnt); end end
      if (c == 3) begin checks++; if (checked_cnt !== 32'd2) begin errors++; $display("FAIL b2b_latency got %0d exp 2", checked_cnt); end end
      if (bus.chk_pc_o != IDLE_PC) begin issues++; run++; end else run = 0;
      if (run > max_run) max_run = run;
    end
    checks++; if (issues != 8 || max_run != 1) begin errors++; $display("FAIL b2b_alternate got issues %0d max_run %0d exp 8/1", issues, max_run); end
    checks++; if (checked_cnt !== 32'd9) begin errors++; $display("FAIL b2b_cnt got %0d exp 9", checked_cnt); end
    checks++; if ({pc_err, insn_err} !== 2'b00) begin errors++; $display("FAIL b2b_errs got %b exp 00", {pc_err, insn_err}); end
  endtask

  task automatic test_pc_miss();
    int n = 0;
    logic acc;
    do_reset();
    set_gold_seq(START_PC, 4);
    push_wait(START_PC, gold_insn[0]);
    push_wait(64'h8000_0004, gold_insn[1]);
    push_wait(64'h8000_000C, gold_insn[3]);
    push_wait(64'h8000_0010, gold_insn[4]);
    idle(12);
    checks++; if ({pc_err, halted, insn_err} !== 3'b110) begin errors++; $display("FAIL miss_flags got pc_err/halted/insn_err %b exp 110", {pc_err, halted, insn_err}); end
    checks++; if (err_pc !== 64'h8000_000C) begin errors++; $display("FAIL miss_err_pc got %0h exp 8000000c", err_pc); end
    checks++; if (err_exp_pc !== 64'h8000_0008) begin errors++; $display("FAIL miss_err_exp got %0h exp 80000008", err_exp_pc); end
    checks++; if (checked_cnt !== 32'd2) begin errors++; $display("FAIL miss_cnt got %0d exp 2", checked_cnt); end
    // The missed head and the entry behind it stay queued, so only DEPTH-2 more fit.
    for (int c = 0; c < 30; c++) begin
      drive_cycle(1'b1, 64'h9000_0000 + xlen_t'(4 * c), '0, acc);
      if (acc) n++;
    end
    bus.ret_valid = 1'b0;
    checks++; if (n != DEPTH - 2) begin errors++; $display("FAIL miss_no_pop got accepted %0d exp %0d", n, DEPTH - 2); end
    checks++; if (bus.chk_pc_o !== IDLE_PC) begin errors++; $display("FAIL halt_chk_pc got %0h exp %0h", bus.chk_pc_o, IDLE_PC); end
  endtask

  task automatic test_insn_mismatch();
    do_reset();
    set_gold_seq(START_PC, 4);
    gold_insn[1] = 32'h0000_0013;
    push_wait(START_PC, gold_insn[0]);
    push_wait(64'h8000_0004, 32'h0010_0093);
    push_wait(64'h8000_0008, gold_insn[2]);
    idle(12);
    checks++; if ({insn_err, pc_err, halted} !== 3'b100) begin errors++; $display("FAIL insn_flags got insn/pc/halt %b exp 100", {insn_err, pc_err, halted}); end
    checks++; if (err_pc !== 64'h8000_0004 || err_exp_pc !== 64'h8000_0004) begin errors++; $display("FAIL insn_err_pcs got %0h/%0h exp 80000004/80000004", err_pc, err_exp_pc); end
    checks++; if (checked_cnt !== 32'd3) begin errors++; $display("FAIL insn_cnt got %0d exp 3", checked_cnt); end
  endtask

  task automatic test_flood();
    int   i = 0;
    logic saw_full = 1'b0;
    logic acc;
    do_reset();
    set_gold_seq(START_PC, 4);
    for (int c = 0; c < 40; c++) begin
      if (!bus.ret_ready) saw_full = 1'b1;
      drive_cycle(1'b1, gold_pc[i], gold_insn[i], acc);
      if (acc) i++;
    end
    idle(100);
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL flood_full got ready_dropped %0b exp 1", saw_full); end
    checks++; if (checked_cnt !== 32'(i)) begin errors++; $display("FAIL flood_cnt got %0d exp %0d", checked_cnt, i); end
    checks++; if ({pc_err, insn_err} !== 2'b00) begin errors++; $display("FAIL flood_errs got %b exp 00", {pc_err, insn_err}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int    n_junk = $urandom_range(0, 3);
      int    n      = $urandom_range(4, 14);
      int    mode   = $urandom_range(0, 2);
      int    j      = $urandom_range(0, n - 1);
      xlen_t p;
      insn_t w;
      do_reset();
      set_gold_seq(START_PC, 2 * $urandom_range(1, 2));
      for (int q = 0; q < n_junk; q++) push_wait(64'h1000 + xlen_t'(4 * q), $urandom);
      for (int q = 0; q < n; q++) begin
        p = gold_pc[q];
        w = gold_insn[q];
        if (q == j && mode == 1) p = p ^ 64'h0100_0000;
        if (q == j && mode == 2) w = w ^ 32'h1;
        idle($urandom_range(0, 2));
        push_wait(p, w);
      end
      idle(60);
      ref_eval();
      checks++; if (synced !== e_synced) begin errors++; $display("FAIL rnd%0d_synced got %0b exp %0b", it, synced, e_synced); end
      checks++; if (checked_cnt !== e_cnt) begin errors++; $display("FAIL rnd%0d_cnt got %0d exp %0d", it, checked_cnt, e_cnt); end
      checks++; if (pc_err !== e_pc_err) begin errors++; $display("FAIL rnd%0d_pc_err got %0b exp %0b", it, pc_err, e_pc_err); end
      checks++; if (insn_err !== e_insn_err) begin errors++; $display("FAIL rnd%0d_insn_err got %0b exp %0b", it, insn_err, e_insn_err); end
      checks++; if (halted !== e_halted) begin errors++; $display("FAIL rnd%0d_halted got %0b exp %0b", it, halted, e_halted); end
      checks++; if (err_pc !== e_err_pc) begin errors++; $display("FAIL rnd%0d_err_pc got %0h exp %0h", it, err_pc, e_err_pc); end
      checks++; if (err_exp_pc !== e_err_exp) begin errors++; $display("FAIL rnd%0d_err_exp got %0h exp %0h", it, err_exp_pc, e_err_exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    logic acc;
    int   leaked = 0;
    do_reset();
    set_gold_seq(START_PC, 4);
    for (int q = 0; q < 5; q++) drive_cycle(1'b1, gold_pc[q], gold_insn[q], acc);
    bus.ret_valid = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (bus.chk_pc_o != IDLE_PC) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_issue got none exp issue within 40 cycles"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.chk_pc_o !== IDLE_PC || bus.ret_ready !== 1'b1) begin errors++; $display("FAIL midrst_pins got chk_pc %0h ready %0b exp %0h 1", bus.chk_pc_o, bus.ret_ready, IDLE_PC); end
    checks++; if ({synced, pc_err, insn_err, halted} !== 4'b0 || checked_cnt !== 32'd0) begin errors++; $display("FAIL midrst_status got flags %b cnt %0d exp 0000 0", {synced, pc_err, insn_err, halted}, checked_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    acc_q.delete();
    @(negedge clk);
    push_wait(64'h2000, '0);
    for (int c = 0; c < 8; c++) begin
      if (bus.chk_pc_o != IDLE_PC) leaked++;
      @(negedge clk);
    end
    checks++; if (leaked != 0 || synced !== 1'b0 || checked_cnt !== 32'd0) begin errors++; $display("FAIL midrst_empty got issues %0d synced %0b cnt %0d exp 0 0 0", leaked, synced, checked_cnt); end
    push_wait(START_PC, gold_insn[0]);
    idle(8);
    checks++; if (synced !== 1'b1 || checked_cnt !== 32'd1) begin errors++; $display("FAIL midrst_resync got synced %0b cnt %0d exp 1 1", synced, checked_cnt); end
  endtask

  initial begin
    bus.ret_valid = 1'b0;
    bus.ret_pc    = '0;
    bus.ret_insn  = '0;
    set_gold_seq(START_PC, 4);
    test_reset();
    test_sync();
    test_back_to_back();
    test_pc_miss();
    test_insn_mismatch();
    test_flood();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/commit_trace_feeder.md
Name: commit_trace_feeder

Overview:
- DUT-side initiator for the co-simulation PC-check interface.
- Accepts retirement events from the core and buffers them in a FIFO.
- Presents each retired PC to the simulator checker, then collects the checker's miss/expected-PC response. Also checks each retired instruction word against the checker's expected instruction.
- Sits between the core retire port and the checker's next_pc_check/next_pc/next_insn/miss pins. Reports sticky errors and a checked-instruction count.

Parameters:
- DEPTH, 16: trace FIFO entries; must be a power of two, at least 2.
- START_PC, 64'h80000000: first PC the checker expects. Retirements before it are discarded.
- IDLE_PC, 64'hFFFFFFFFFFFFFFFF: sentinel driven on chk_pc_o whenever no check is in flight. It must never equal a real PC.
- HALT_ON_ERR, 1: 1 = stop issuing after the first PC miss; 0 = log the miss and continue.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ret_valid  in  1  core retired an instruction this cycle
- ret_pc  in  64  PC of the retired instruction
- ret_insn  in  32  encoding of the retired instruction
- ret_ready  out  1  FIFO not full; retirement accepted when ret_valid && ret_ready
- chk_pc_o  out  64  PC under check; connects to the checker's next_pc_check
- chk_pc_i  in  64  checker's current expected PC (its next_pc)
- chk_insn_i  in  32  checker's current expected instruction (its next_insn)
- chk_miss_i  in  1  checker miss flag, valid one cycle after the issue
- synced  out  1  START_PC has been seen
- checked_cnt  out  32  number of PC matches, wraps modulo 2^32
- pc_err  out  1  sticky: at least one PC miss
- insn_err  out  1  sticky: at least one instruction-word mismatch
- err_pc  out  64  DUT PC of the first error
- err_exp_pc  out  64  checker's expected PC at the first error
- halted  out  1  in HALT state

Behaviour:
- Reset (async assert, sync release): FIFO empty; state SYNC.
  - chk_pc_o = IDLE_PC; ret_ready = 1.
  - synced, pc_err, insn_err, halted, checked_cnt, err_pc, err_exp_pc = 0.
  - exp_valid = 0. Reset mid-check abandons the in-flight entry.
- FIFO:
  - Push on ret_valid && ret_ready; pop only as stated below.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - When full, ret_ready = 0 and the push is refused even if a pop occurs that cycle.
- chk_pc_o is registered. It equals the head PC only during ISSUE and is IDLE_PC in every other state. This prevents the checker, which compares every clock, from advancing spuriously.
- States:
  - SYNC: if the FIFO is non-empty and head.pc != START_PC, pop and discard (one per cycle). If head.pc == START_PC, set synced and go to ISSUE without popping.
  - IDLE: go to ISSUE when the FIFO is non-empty.
  - ISSUE (1 cycle): drive head.pc; go to WAIT.
  - WAIT (1 cycle): sample chk_miss_i, chk_pc_i, chk_insn_i.
    - Miss = 0:
      - Pop; checked_cnt++.
      - If exp_valid && head.insn != exp_insn, set insn_err.
      - exp_insn <= chk_insn_i; exp_valid <= 1.
      - Go to ISSUE if more entries remain, otherwise IDLE.
    - Miss = 1:
      - Set pc_err.
      - If HALT_ON_ERR, go to HALT without popping.
      - Otherwise pop, clear exp_valid, and go to ISSUE/IDLE.
  - HALT: terminal until reset. chk_pc_o = IDLE_PC; pushes continue until the FIFO is full.
- err_pc and err_exp_pc load only on the first error of either kind:
  - PC miss: head.pc and chk_pc_i.
  - Insn mismatch: head.pc and the checked PC.
- Throughput is one check per 2 cycles; latency from push into an empty FIFO to the checked_cnt update is 3 cycles.
- Simultaneous PC miss and insn mismatch in one WAIT: only pc_err is set; the insn check is skipped on a miss.

Decomposition:
- Package sim_intf_pkg: xlen_t (64b), insn_t (32b), trace_entry_t {pc, insn}, state enum {SYNC, IDLE, ISSUE, WAIT, HALT}, default IDLE_PC.
- Sub-module trace_fifo: parameterised DEPTH, trace_entry_t payload, full/empty/push/pop, async active-low reset. The top block holds the FSM, error logic and counter.

Test Plan:
- Push PCs 0x1000, 0x1004, then 0x80000000 → first two discarded, synced = 1, chk_pc_o = 0x80000000 for exactly 1 cycle; checker model matches → checked_cnt = 1.
- Push 8 back-to-back sequential PCs after sync, model always matches → chk_pc_o alternates PC/IDLE_PC; checked_cnt = 8 after 16 cycles; pc_err = 0.
- Model returns miss = 1 with chk_pc_i = 0x80000008 for DUT PC 0x8000000C, HALT_ON_ERR = 1 → pc_err = 1, err_pc = 0x8000000C, err_exp_pc = 0x80000008, halted = 1, head not popped.
- Model's chk_insn_i after PC 0x80000000 is 0x00000013, DUT retires 0x80000004 with insn 0x00100093 → insn_err = 1, pc_err = 0, err_pc = 0x80000004.
- Hold ret_valid = 1 for 40 cycles with DEPTH = 16 → ret_ready drops at full; no entry lost or duplicated; all accepted PCs checked in order.
- Assert rst_n low during WAIT with 5 entries queued → all outputs at reset values immediately; after release, the state is SYNC and the FIFO is empty.
